reg_file: RTL
=============

# reg_file

Integer register file for the single-cycle rv32i core: 32 x 32-bit architectural registers (x0 through x31), two asynchronous read ports and one synchronous write port. It sits directly upstream of the ALU:
- read port 1 drives the ALU's `in_a` operand;
- read port 2 drives `in_b` (directly, or via the immediate mux);
- the ALU `result` (or load data) returns through the write port.

x0 is hard-wired to zero.

## Interface
Parameters:
- `WIDTH`, 32, register data width.
- `BYPASS`, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return the stored value only.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on rising `clk`.
- `wen`  in  1  write enable for the current cycle.
- `rd`  in  5  destination register index.
- `wr_data`  in  WIDTH  write data.
- `rs1`  in  5  read port 1 index.
- `rs2`  in  5  read port 2 index.
- `rd_data1`  out  WIDTH  contents of `rs1` (feeds ALU `in_a`).
- `rd_data2`  out  WIDTH  contents of `rs2` (feeds ALU `in_b` path).

## Operation
- Storage: 31 physical registers for x1 through x31; x0 has no storage.

Write:
- On a rising edge with `rst_n`=1, `wen`=1 and `rd`!=0, `regs[rd]` <= `wr_data`.
- A write to `rd`=0 is silently discarded.
- `wen`=0 leaves all registers unchanged.

Read (combinational):
- `rd_data1` = 0 if `rs1`==0, else `regs[rs1]`.
- `rd_data2` is defined identically on `rs2`.

Bypass, `BYPASS`=1 only:
- If `wen`=1, `rd`!=0, `rst_n`=1 and `rs1`==`rd`, then `rd_data1` = `wr_data` in the same cycle.
- `rd_data2` follows the same rule on `rs2`.
- Both ports may bypass simultaneously when `rs1`==`rs2`==`rd`.
- x0 is never bypassed. Reading x0 returns 0 even while x0 is being "written".

Reset:
- A rising edge with `rst_n`=0 clears x1 through x31 to 0.
- Reset has priority over a coincident write; that write is lost.
- While `rst_n`=0, bypass is suppressed, so reads return stored values.

General:
- No arithmetic; data is stored and returned unmodified at full `WIDTH`. Indices are 5 bits, so there are no out-of-range cases.

## Timing
- Read latency: 0 cycles; outputs depend combinationally on `rs1`/`rs2` and stored state.
- Write latency: 1 cycle.
  - The value is visible through storage from the cycle after the write edge.
  - With `BYPASS`=1 it is also visible in the write cycle itself.
  - With `BYPASS`=0, a read-during-write to the same index returns the old value.
- Reset values:
  - All registers are 0 after the first rising edge with `rst_n`=0.
  - `rd_data1` and `rd_data2` read 0 for every index from that edge until the next write.
- Before the first reset edge, register contents are undefined, except that x0 reads 0.
- Reset mid-operation: any write pending in the reset cycle is dropped; the next cycle reads 0 everywhere.
- Back-to-back writes to the same `rd`: last write wins. Each intermediate value is readable in its own cycle via bypass (`BYPASS`=1) or in the following cycle via storage.
- Single write port only: there is no write-write conflict case.

## Test plan
- Reset: write 0xDEADBEEF to x5, then hold `rst_n`=0 for one edge -> `rd_data1` with `rs1`=5 reads 0x00000000; a sweep of all 32 indices on both ports reads 0.
- x0 immunity: `wen`=1, `rd`=0, `wr_data`=0xFFFFFFFF, `rs1`=`rs2`=0 -> both outputs 0 in the write cycle and the following cycle.
- Write/read all: write x_i = 0x1000_0000 + i for i=1..31 on consecutive cycles, then read pairs (`rs1`=i, `rs2`=32-i) -> exact stored values on both ports; no aliasing.
- Read-during-write, `BYPASS`=1: x7 holds 0x11111111; write 0x22222222 to x7 with `rs1`=`rs2`=7 -> both outputs 0x22222222 in the same cycle. With `BYPASS`=0 -> 0x11111111 in that cycle and 0x22222222 in the next.
- Reset vs. write collision: `rst_n`=0 and `wen`=1, `rd`=3, `wr_data`=0xABCD0123 on the same edge -> x3 reads 0 afterwards; no bypass of 0xABCD0123 during that cycle.
- ALU hookup: x1=7, x2=5, `rs1`=1, `rs2`=2 feeding ALU sub (op 0110) -> ALU result 2. Writing the result back to x3 and re-reading gives 0x00000002.

Source files
------------

// File: rtl/reg_file.sv
// rv32i integer register file: 31 stored registers (x0 hard-wired to zero),
// two combinational read ports and one synchronous write port with optional forwarding.
module reg_file #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [4:0]       rd,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2
);

    localparam int unsigned NREGS = 32;

    logic [WIDTH-1:0] regs_q [1:NREGS-1];
    logic [WIDTH-1:0] regs_d [1:NREGS-1];
    logic             wr_en;
    logic             byp_en;

    // Writes to x0 have no storage to land in and are dropped here.
    assign wr_en  = wen && (rd != 5'd0);
    assign byp_en = BYPASS && rst_n && wr_en;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd] = wr_data;
        end
    end

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding only fires for rd != 0, so x0 always reads zero.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rs1 != 5'd0) begin
            rd_data1 = regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rd_data2 = regs_q[rs2];
        end
        if (byp_en && (rs1 == rd)) begin
            rd_data1 = wr_data;
        end
        if (byp_en && (rs2 == rd)) begin
            rd_data2 = wr_data;
        end
    end

endmodule
